// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder for the multicycle core.
// Accepts one request in IDLE, waits LAT cycles, then returns a one-cycle
// registered response. Writes are byte-strobed and land at the clock edge
// that ends the response cycle. A registered debug port reads any word.
//
// Handshake: req is sampled only while IDLE. ready is a one-cycle strobe;
// rdata and err are meaningful only while ready=1 and are zero otherwise.
// Request fields are captured once and ignored until the next IDLE.
module mem_responder #(
  parameter int N     = 64,
  parameter int DEPTH = 256,
  parameter int LAT   = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int SW   = N / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [N-1:0]  adr,
  input  logic [N-1:0]  wdata,
  input  logic [SW-1:0] wstrb,
  output logic [N-1:0]  rdata,
  output logic          ready,
  output logic          err,
  input  logic [AW-1:0] checka,
  output logic [N-1:0]  check,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        st;
  logic [3:0]    count;
  logic          we_q;
  logic          bad_q;
  logic [AW-1:0] idx_q;
  logic [N-1:0]  wdata_q;
  logic [SW-1:0] wstrb_q;

  logic [N-1:0]  mem [DEPTH];

  logic          adr_bad;
  logic          cur_we;
  logic          cur_bad;
  logic [AW-1:0] cur_idx;
  logic [N-1:0]  cur_wdata;
  logic [SW-1:0] cur_strb;
  logic [N-1:0]  rd_word;
  logic [N-1:0]  merged;
  logic [N-1:0]  resp_data;

  assign state = st;

  // Misaligned or beyond the last word: any nonzero byte offset or upper bit.
  assign adr_bad = (adr[2:0] != 3'b000) || (adr[N-1:AW+3] != '0);

  // In IDLE the live inputs feed the response path (needed when LAT=0);
  // afterwards only the captured copies are used.
  always_comb begin
    cur_we    = we_q;
    cur_bad   = bad_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_strb  = wstrb_q;
    if (st == IDLE) begin
      cur_we    = we;
      cur_bad   = adr_bad;
      cur_idx   = adr[AW+2:3];
      cur_wdata = wdata;
      cur_strb  = wstrb;
    end
  end

  // Merge enabled byte lanes over the stored word; rdata shows the result.
  always_comb begin
    rd_word = mem[cur_idx];
    merged  = rd_word;
    for (int i = 0; i < SW; i++) begin
      if (cur_strb[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
    end
    resp_data = '0;
    if (!cur_bad) resp_data = cur_we ? merged : rd_word;
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= IDLE;
      count   <= 4'd0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (st)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            bad_q   <= adr_bad;
            idx_q   <= adr[AW+2:3];
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            count   <= 4'(LAT);
            if (LAT > 0) begin
              st <= WAIT;
            end else begin
              st    <= RESP;
              ready <= 1'b1;
              err   <= adr_bad;
              rdata <= resp_data;
            end
          end
        end
        WAIT: begin
          if (count != 4'd0) count <= count - 4'd1;
          if (count == 4'd1) begin
            st    <= RESP;
            ready <= 1'b1;
            err   <= bad_q;
            rdata <= resp_data;
          end
        end
        RESP: begin
          st <= IDLE;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

  // Write lands at the edge ending RESP; an aborted request never gets here.
  always_ff @(posedge clk) begin
    if (st == RESP && we_q && !bad_q) mem[idx_q] <= merged;
  end

  // Debug read port, one-cycle latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) check <= '0;
    else        check <= mem[checka];
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory responder for the 64-bit multicycle core; it services the datapath's memory requests from the other side of the address/write-data/read-data interface. It accepts one request at a time over a req/ready handshake, inserts a programmable number of wait states, and performs byte-strobed 64-bit writes or full-word reads. It flags misaligned or out-of-range accesses, and a registered debug read port lets the test harness inspect memory without disturbing traffic.

## Interface
Parameters:
- N, 64, data and address width (multiple of 8)
- DEPTH, 256, number of N-bit words (power of 2)
- LAT, 2, wait states inserted before the response (0..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- req  in  1  request valid; sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- adr  in  N  byte address
- wdata  in  N  write data
- wstrb  in  N/8  byte-lane write enables; bit i covers wdata[8i+7:8i]
- rdata  out  N  response data, valid while ready=1
- ready  out  1  one-cycle response strobe
- err  out  1  error flag, valid while ready=1
- checka  in  log2(DEPTH)  debug word index
- check  out  N  debug read data, registered

## Operation
- States are IDLE, WAIT and RESP.
- IDLE:
  - If req=1, capture adr, we, wdata and wstrb.
  - Compute bad = (adr[2:0]!=0) or (adr >= DEPTH*8).
  - Load count=LAT. If LAT>0, go to WAIT; otherwise go to RESP.
  - If req=0, stay in IDLE.
- WAIT: decrement count each cycle. When count reaches 1, the next state is RESP. WAIT lasts exactly LAT cycles.
- RESP (single cycle):
  - ready=1.
  - If bad: err=1, rdata=0, memory untouched.
  - Else read: rdata=mem[idx], where idx=adr[log2(DEPTH)+2:3].
  - Else write: lanes with wstrb[i]=1 are updated at the clock edge ending RESP. rdata shows the merged word, i.e. the post-write value.
  - Always return to IDLE.
- req, adr, we, wdata and wstrb are ignored outside IDLE; they are captured once and later changes are not seen.
- A req still high in the IDLE cycle after ready counts as a new request. The requester drops req on the cycle it sees ready.
- wstrb=0 on a write: normal response, err=0, memory unchanged.
- Debug port: check <= mem[checka] every clock, with one-cycle latency. A same-cycle RESP write is not visible until the following cycle.
- Memory contents are not cleared by reset. Simulation preloads them through the harness.

## Timing
- Reset asserted (async): state=IDLE, count=0, ready=0, err=0, rdata=0, check=0. All captured request fields are cleared.
- Reset asserted in WAIT or RESP aborts the request. No memory write occurs and no ready is issued.
- Latency: req sampled at edge k in IDLE gives ready=1 during cycle k+LAT+1. The minimum request-to-request spacing is LAT+2 cycles.
- ready, err and rdata are registered. Outside RESP they hold ready=0 and err=0, and rdata returns to 0.
- count is 4 bits and never wraps; LAT=0 bypasses WAIT entirely.

## Test plan
- Read after preload, LAT=2: mem[3]=64'h0123_4567_89AB_CDEF; req=1, we=0, adr=0x18 at edge 0 -> ready=1 in cycle 3, rdata=64'h0123_4567_89AB_CDEF, err=0.
- Byte-strobed write: mem[1]=64'hFFFF_FFFF_FFFF_FFFF; write adr=0x08, wdata=64'h0, wstrb=8'h0F -> rdata=64'hFFFF_FFFF_0000_0000 on ready; check with checka=1 shows the same value two edges after RESP.
- Errors: read adr=0x0C -> ready=1, err=1, rdata=0; write adr=DEPTH*8 -> err=1, and checka sweep shows no memory change.
- LAT=0 back-to-back: req held high for 4 cycles -> ready pulses every 2 cycles, two responses total, no response lost or duplicated.
- Reset mid-WAIT: write issued, reset=0 one cycle later -> ready never asserts, target word unchanged, all outputs 0 until reset=1.
- Input change after capture: adr switched from 0x10 to 0x20 during WAIT -> response carries mem[2], not mem[4].
